// File: rtl/mdio_master.sv
// mdio_master: Wishbone-fronted Clause 22 MDIO station that runs one register read or write per bus cycle.
module mdio_master #(
   parameter int CLK_DIV      = 2,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [4:0]  phyad,
   input  logic [4:0]  regad,
   input  logic [15:0] data_write,
   output logic        ack,
   output logic        err,
   output logic [15:0] data_read,
   output logic        mdc,
   output logic        mdo,
   output logic        mdo_oe,
   input  logic        mdi
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [8:0] HALF = 9'(CLK_DIV - 1);
   localparam logic [8:0] FULL = 9'(2 * CLK_DIV - 1);
   localparam logic [6:0] OER  = 7'(PREAMBLE_LEN + 14);
   localparam logic [6:0] TA2  = 7'(PREAMBLE_LEN + 15);
   localparam logic [6:0] D0   = 7'(PREAMBLE_LEN + 16);
   localparam logic [6:0] LAST = 7'(PREAMBLE_LEN + 32);

   state_t      state, state_n;
   logic [8:0]  div, div_n;
   logic [6:0]  bitn, bitn_n;
   logic [64:0] sr, sr_n;
   logic        rd, rd_n, drop, drop_n, nophy, nophy_n;
   logic        ack_n, err_n, mdc_n, mdo_oe_n, mdi_m, mdi_s;
   logic [15:0] data_read_n;

   // sr holds the whole outgoing frame MSB first; its top bit is the wire value, and
   // reads pad TA/DATA with ones so mdo idles high while the PHY drives the line
   assign mdo = sr[64];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         div       <= '0;
         bitn      <= '0;
         sr        <= '1;
         rd        <= 1'b0;
         drop      <= 1'b0;
         nophy     <= 1'b0;
         data_read <= '0;
         ack       <= 1'b0;
         err       <= 1'b0;
         mdc       <= 1'b0;
         mdo_oe    <= 1'b0;
         mdi_m     <= 1'b1;
         mdi_s     <= 1'b1;
      end else begin
         state     <= state_n;
         div       <= div_n;
         bitn      <= bitn_n;
         sr        <= sr_n;
         rd        <= rd_n;
         drop      <= drop_n;
         nophy     <= nophy_n;
         data_read <= data_read_n;
         ack       <= ack_n;
         err       <= err_n;
         mdc       <= mdc_n;
         mdo_oe    <= mdo_oe_n;
         mdi_m     <= mdi;
         mdi_s     <= mdi_m;
      end
   end

   always_comb begin
      state_n     = state;
      div_n       = div;
      bitn_n      = bitn;
      sr_n        = sr;
      rd_n        = rd;
      drop_n      = drop;
      nophy_n     = nophy;
      data_read_n = data_read;
      ack_n       = 1'b0;
      err_n       = 1'b0;
      mdc_n       = mdc;
      mdo_oe_n    = mdo_oe;
      if (state == IDLE) begin
         if (cyc && stb && !ack && !err) begin
            state_n     = SHIFT;
            div_n       = '0;
            bitn_n      = '0;
            rd_n        = !we;
            drop_n      = 1'b0;
            nophy_n     = 1'b0;
            data_read_n = '0;
            mdc_n       = 1'b0;
            mdo_oe_n    = 1'b1;
            sr_n        = {32'hFFFF_FFFF, 2'b01, we ? 2'b01 : 2'b10, phyad, regad,
                           we ? {2'b10, data_write} : 18'h3FFFF, 1'b1} << (32 - PREAMBLE_LEN);
         end
      end else if (state == SHIFT) begin
         drop_n = drop || !cyc;
         mdc_n  = (div == HALF) ? 1'b1 : mdc;
         div_n  = div + 9'd1;
         if (div == FULL) begin
            div_n    = '0;
            mdc_n    = 1'b0;
            nophy_n  = nophy || (rd && bitn == TA2 && mdi_s);
            data_read_n = (rd && bitn >= D0 && bitn < LAST) ? {data_read[14:0], mdi_s} : data_read;
            bitn_n   = bitn + 7'd1;
            sr_n     = {sr[63:0], 1'b1};
            mdo_oe_n = bitn_n < (rd ? OER : LAST);
            if (bitn == LAST) begin
               state_n  = drop_n ? IDLE : DONE;
               ack_n    = !drop_n && !(rd && nophy);
               err_n    = !drop_n && rd && nophy;
               sr_n     = '1;
               mdo_oe_n = 1'b0;
            end
         end
      end else begin
         state_n = IDLE;
      end
   end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause 22 MDIO management station (STA). A Wishbone classic slave accepts one register read or write, serialises it as an MDC/MDIO frame, and returns read data with ack.
- Sits on the MAC/host side. It drives the MDIO responder/register file of our PHY, or any external PHY.
- A missing PHY is reported as err, detected by the turnaround bit not being driven low.

Parameters:
- CLK_DIV, 2, clk cycles per MDC half period; legal range 1..255.
- PREAMBLE_LEN, 32, number of leading 1 bits; legal range 0..32.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cyc  in  1  Wishbone cycle
- stb  in  1  Wishbone strobe
- we  in  1  1=write, 0=read
- phyad  in  5  PHY address
- regad  in  5  register address
- data_write  in  16  write data
- ack  out  1  transaction done, registered
- err  out  1  read found no PHY, registered
- data_read  out  16  read data, valid while ack/err
- mdc  out  1  management clock
- mdo  out  1  MDIO output value
- mdo_oe  out  1  MDIO output enable (1 = drive)
- mdi  in  1  MDIO pad input, asynchronous

Behaviour:
- Reset (rst_n=0 at posedge): mdc=0, mdo=1, mdo_oe=0, ack=0, err=0, data_read=0, state IDLE.
- Reset mid-frame aborts immediately. Outputs take reset values at that edge and no ack/err is issued.
- mdi passes through a 2-flop synchroniser before any use.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when cyc&&stb at a posedge and ack/err are both low at that edge.
  - Latch we, phyad, regad, data_write at that edge.
  - Later changes to these inputs are ignored until the next acceptance.
- Bit period = 2*CLK_DIV clk cycles.
  - mdc is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV.
  - mdo and mdo_oe change only at bit start, i.e. on the same edge where mdc goes 0.
- Frame bit order, N=PREAMBLE_LEN, all fields MSB first:
  - bits 0..N-1: 1
  - ST: 01
  - OP: 01 for write, 10 for read
  - PHYAD: 5 bits
  - REGAD: 5 bits
  - TA: 2 bits
  - DATA: 16 bits
  - then 1 idle bit
  - Total N+33 bits.
- Write: mdo_oe=1 for bits 0..N+31. TA driven as 1,0; DATA = latched data_write.
- Read: mdo_oe=1 for bits 0..N+13; mdo_oe=0 from the first TA bit through end of frame.
- Read sampling: the synchronised mdi is sampled on the last clk cycle of each bit (end of the mdc-high phase).
  - Second TA bit sample must be 0; otherwise flag no-PHY.
  - DATA bits are shifted into data_read MSB first.
- Idle bit: mdo_oe=0, mdo=1. mdc keeps toggling through it. After it, mdc stays 0 in IDLE.
- DONE: a one-cycle pulse.
  - ack=1 for a write or a good read; err=1 for a read with no-PHY (data_read then shows the sampled bits, 0xFFFF with a pull-up).
  - ack and err are never both 1.
  - Ack/err edge = acceptance edge + (N+33)*2*CLK_DIV clk cycles. Default: 65*4 = 260.
- Writes never produce err. data_read on a write ack = 0.
- No acceptance in the cycle ack/err is high. The earliest next acceptance is the edge after the pulse.
- cyc dropped mid-frame: the frame still completes on the wire, with no ack/err pulse, then return to IDLE.
- stb while busy is ignored; not queued.

Test Plan:
- Default params; write phyad=1, regad=0, data_write=0x8000 -> mdo sampled per bit:
  - 32x1, 0101, 00001, 00000, 10, 1000000000000000
  - mdo_oe=1 for bits 0..63, 0 for bit 64
  - ack single pulse 260 cycles after acceptance; err=0.
- Read phyad=3, regad=2 with bench PHY model driving TA=Z,0 and data 0x7809 on MDC rising edges -> mdo_oe drops at bit 46; ack pulse at 260; data_read=0x7809; err=0.
- Read with mdi held 1 (no PHY) -> err pulse at 260, ack=0, data_read=0xFFFF.
- rst_n=0 for one cycle during bit 40 of a write -> next edge mdc=0, mdo_oe=0, mdo=1, no ack/err ever. A following write frames correctly.
- cyc dropped during bit 10 -> full 65-bit frame on wire, no ack/err. Back-to-back reads with stb held -> second accepted exactly 1 cycle after first ack, no duplicate acceptance on the ack edge.
- PREAMBLE_LEN=0, CLK_DIV=1 read -> 33-bit frame starting with 0110, mdc period 2 clks, ack at 66 cycles.
